scene_sequencer: RTL
====================

// Module: scene_sequencer
// PURPOSE
//   Top-level draw controller for the 160x120, 3-bit-colour VGA path. On one start request it
//   clears the screen via fillscreen, then draws one circle via the circle engine. It owns the
//   single VGA adapter plot port and grants it to exactly one engine at a time.
//   Sits between the lab top level (switches/keys) and the fillscreen/circle datapaths.
// PARAMETERS
//   CLEAR_EN        1      1: run the fillscreen stage before the circle; 0: skip it.
//   WATCHDOG_CYCLES 65535  Max cycles a stage may hold start without done before abort (>=19200).
// PORTS
//   clk          in   1  system clock (50 MHz)
//   rst_n        in   1  asynchronous active-low reset
//   start        in   1  request; held high by requester until done seen
//   done         out  1  sequence complete; held until start drops
//   error        out  1  sticky watchdog abort flag; cleared on next accepted start
//   bg_colour    in   3  clear colour;  fg_colour in 3 circle colour
//   centre_x     in   8  circle centre x; centre_y in 7 centre y; radius in 8 circle radius
//   fill_start   out  1  to fillscreen; fill_colour out 3 (latched bg_colour)
//   fill_done    in   1  from fillscreen; fill_x in 8, fill_y in 7, fill_c in 3, fill_plot in 1
//   circ_start   out  1  to circle; circ_colour out 3, circ_cx out 8, circ_cy out 7, circ_r out 8
//   circ_done    in   1  from circle; circ_x in 8, circ_y in 7, circ_c in 3, circ_plot in 1
//   vga_x out 8, vga_y out 7, vga_colour out 3, vga_plot out 1   to VGA adapter
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; done, error, fill_start, circ_start, vga_plot = 0;
//     vga_x/y/colour = 0; latched operands = 0. Reset mid-sequence aborts immediately.
//   States: IDLE, FILL, FILL_REL, CIRC, CIRC_REL, DONE.
//   IDLE: start=1 at posedge -> latch bg/fg/centre/radius, clear error; go FILL (CLEAR_EN=1)
//     or CIRC (CLEAR_EN=0). Latched copies drive fill_*/circ_* operands; inputs ignored after.
//   FILL: fill_start=1 (Moore, first cycle after start sampled). fill_done=1 -> FILL_REL.
//   FILL_REL: fill_start=0; stay until fill_done=0 (min 1 cycle) -> CIRC.
//   CIRC: circ_start=1. circ_done=1 -> CIRC_REL. CIRC_REL: circ_start=0; wait circ_done=0 -> DONE.
//   DONE: done=1; start=0 -> IDLE. start dropped early during a stage is ignored; sequence runs
//     to completion and done then shows for exactly 1 cycle.
//   Child start never re-asserts until that child's done has been seen low.
//   Watchdog: counter cleared on entry to FILL/CIRC, increments each cycle in that state;
//     reaching WATCHDOG_CYCLES -> error=1, child start dropped, go DONE (remaining stage skipped).
//   Port grant (combinational mux on state): FILL -> fill_*; CIRC -> circ_*; all other states
//     vga_plot=0 and x/y/colour=0. Zero added latency from child plot to vga_plot.
//   Clipping: vga_plot forced 0 when granted x>=160 or y>=120 (circle octants off-screen);
//     x/y/colour still passed through.
//   Ungranted engine's plot is never forwarded, even if asserted.
// TESTING
//   1 Reset mid-FILL (rst_n low 1 cycle) -> all outputs 0, state IDLE, fill_start=0 same cycle.
//   2 bg=3'b000, fg=3'b010, centre (80,60), r=40, CLEAR_EN=1 -> 19200 fill plots of colour 0,
//     then circle plots colour 2; done=1 after circ_done low; done drops 1 cycle after start=0.
//   3 centre (150,110), r=40 -> every vga_plot=1 pixel has x<160, y<120; off-screen points dropped.
//   4 Stub fillscreen holding fill_done=0 forever, WATCHDOG_CYCLES=100 -> error=1 after 100
//     cycles, circ_start never asserts, done=1; next start clears error.
//   5 Stub engines assert plot outside their grant -> vga_plot stays 0; fill_done stuck high
//     1 extra 5 cycles -> circ_start waits until fill_done=0.
//   6 CLEAR_EN=0; change bg/centre inputs mid-draw -> no fill stage; circle uses values latched at start.

Source files
------------

// File: rtl/scene_sequencer.sv
// Sequences a screen clear (fillscreen) and one circle draw, arbitrating the single VGA plot port.
// Latency: child start one cycle after start sampled; child plot reaches vga_plot combinationally.
// Backpressure: start/done four-phase handshake with requester and each child; watchdog bounds each stage.
module scene_sequencer #(
  parameter bit          CLEAR_EN        = 1'b1,
  parameter int unsigned WATCHDOG_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       done,
  output logic       error,
  input  logic [2:0] bg_colour,
  input  logic [2:0] fg_colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  output logic       fill_start,
  output logic [2:0] fill_colour,
  input  logic       fill_done,
  input  logic [7:0] fill_x,
  input  logic [6:0] fill_y,
  input  logic [2:0] fill_c,
  input  logic       fill_plot,
  output logic       circ_start,
  output logic [2:0] circ_colour,
  output logic [7:0] circ_cx,
  output logic [6:0] circ_cy,
  output logic [7:0] circ_r,
  input  logic       circ_done,
  input  logic [7:0] circ_x,
  input  logic [6:0] circ_y,
  input  logic [2:0] circ_c,
  input  logic       circ_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam int unsigned WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FILL, FILL_REL, CIRC, CIRC_REL, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  bg_q, fg_q;
  logic [7:0]  cx_q, r_q;
  logic [6:0]  cy_q;
  logic [WW-1:0] wd_cnt;
  logic        error_q;
  logic        accept;
  logic        abort;
  logic        plot_raw;

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand snapshot taken when a start is accepted; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_q <= '0;
      fg_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      r_q  <= '0;
    end else if (accept) begin
      bg_q <= bg_colour;
      fg_q <= fg_colour;
      cx_q <= centre_x;
      cy_q <= centre_y;
      r_q  <= radius;
    end
  end

  // Watchdog: restarts on every state change, counts while a child stage is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              wd_cnt <= '0;
    else if (state_nxt != state)             wd_cnt <= '0;
    else if (state == FILL || state == CIRC) wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky abort flag, cleared only by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      error_q <= 1'b0;
    else if (accept) error_q <= 1'b0;
    else if (abort)  error_q <= 1'b1;
  end

  // Next-state, child handshakes and plot-port grant.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    abort      = 1'b0;
    fill_start = 1'b0;
    circ_start = 1'b0;
    done       = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    plot_raw   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CLEAR_EN ? FILL : CIRC;
        end
      end
      FILL: begin
        fill_start = 1'b1;
        vga_x      = fill_x;
        vga_y      = fill_y;
        vga_colour = fill_c;
        plot_raw   = fill_plot;
        if (fill_done) begin
          state_nxt = FILL_REL;
        end else if (wd_cnt == WD_LAST) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      FILL_REL: begin
        if (!fill_done) state_nxt = CIRC;
      end
      CIRC: begin
        circ_start = 1'b1;
        vga_x      = circ_x;
        vga_y      = circ_y;
        vga_colour = circ_c;
        plot_raw   = circ_plot;
        if (circ_done) begin
          state_nxt = CIRC_REL;
        end else if (wd_cnt == WD_LAST) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      CIRC_REL: begin
        if (!circ_done) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Off-screen points (circle octants past the edge) are suppressed; coordinates still pass.
  assign vga_plot    = plot_raw && (vga_x < 8'd160) && (vga_y < 7'd120);
  assign error       = error_q;
  assign fill_colour = bg_q;
  assign circ_colour = fg_q;
  assign circ_cx     = cx_q;
  assign circ_cy     = cy_q;
  assign circ_r      = r_q;

endmodule
